// File: rtl/bit_serial_subtractor.sv
// Purpose : LSB-first bit-serial subtractor, diff = a - b - b_in, one full-subtractor cell.
// Latency : start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpr. : none; start is ignored while busy, accepted again in IDLE or DONE.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request, sampled only when not busy
//   a, b, b_in      operands and borrow-in, captured on an accepted start
//   busy            high while bits are being processed
//   done            one-cycle pulse, diff/b_out valid
//   diff, b_out     result and final borrow, held until the next result lands
//   ovf             signed overflow flag, present only with `define SUB_OVERFLOW_EN
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  // a_sh doubles as the result shift register: each consumed minuend bit
  // leaves at the LSB while the matching difference bit enters at the MSB,
  // so after WIDTH shifts it holds the full difference.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell.
  logic d;
  logic br_nxt;
  assign d      = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  logic accept;
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SUB_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          a_sh <= {d, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Last bit: publish the result only now so diff never shows
            // partial shift contents.
            diff  <= {d, a_sh[WIDTH-1:1]};
            b_out <= br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SUB_OVERFLOW_EN
            // d is the result MSB; overflow when operand signs differ and
            // the result sign differs from the minuend's.
            ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Purpose : directed checks of bit_serial_subtractor at WIDTH=8 and exhaustive WIDTH=2.
// Latency : expects done WIDTH+1 cycles after the start edge.
// Backpr. : exercises start-while-busy, back-to-back start in DONE, reset mid-op.
module tb_bit_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
`ifdef SUB_OVERFLOW_EN
  logic       ovf8;
  logic       ovf2;
`endif

  logic       start2, bin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  int total = 0;
  int bad   = 0;
  int dones2 = 0;

  bit_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .b_in  (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
`ifdef SUB_OVERFLOW_EN
    .ovf   (ovf8),
`endif
    .b_out (bout8)
  );

  bit_serial_subtractor #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .b_in  (bin2),
    .busy  (busy2),
    .done  (done2),
    .diff  (diff2),
`ifdef SUB_OVERFLOW_EN
    .ovf   (ovf2),
`endif
    .b_out (bout2)
  );

  always @(negedge clk) if (done2) dones2++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output int lat, output int busyc, output int diffchg);
    logic [7:0] d0;
    d0 = diff8;
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
    lat = 0; busyc = 0; diffchg = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (busy8) busyc++;
      if (done8) break;
      if (diff8 !== d0) diffchg++;
    end
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin, output int lat);
    start2 = 1'b1; a2 = a; b2 = b; bin2 = bin;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = ~a; b2 = ~b; bin2 = ~bin;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done2) break;
    end
  endtask

  initial begin
    int lat, busyc, dchg, nd;
    logic [7:0] dcap;
    logic       bcap;
    logic [1:0] ed;
    logic       eb;

    reset = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; bin2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 8'h00);
    check("rst_bout", bout8, 0);

    // Basic subtract
    op8(8'h5A, 8'h23, 1'b0, lat, busyc, dchg);
    check("basic_lat", lat, 9);
    check("basic_busy", busyc, 8);
    check("basic_hold", dchg, 0);
    check("basic_diff", diff8, 8'h37);
    check("basic_bout", bout8, 0);
    @(negedge clk);
    check("basic_pulse", done8, 0);

    // Borrow out, then back-to-back start in the DONE cycle
    op8(8'h00, 8'h01, 1'b0, lat, busyc, dchg);
    check("brw_lat", lat, 9);
    check("brw_diff", diff8, 8'hFF);
    check("brw_bout", bout8, 1);
    op8(8'h10, 8'h0F, 1'b1, lat, busyc, dchg);
    check("b2b_lat", lat, 9);
    check("b2b_hold", dchg, 0);
    check("b2b_diff", diff8, 8'h00);
    check("b2b_bout", bout8, 0);

    // Start while busy
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(posedge clk); #1 start8 = 1'b0;
    nd = 0; dcap = 0; bcap = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done8) begin nd++; dcap = diff8; bcap = bout8; end
    end
    check("busyst_ndone", nd, 1);
    check("busyst_diff", dcap, 8'hE1);
    check("busyst_bout", bcap, 0);
    check("busyst_idle", busy8, 0);

    // Reset mid-operation (start asserted with it is ignored)
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; start8 = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rmid_busy", busy8, 0);
    check("rmid_done", done8, 0);
    check("rmid_diff", diff8, 8'h00);
    check("rmid_bout", bout8, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    check("rmid_quiet", nd, 0);
    op8(8'h02, 8'h01, 1'b0, lat, busyc, dchg);
    check("rmid_lat", lat, 9);
    check("rmid_diff2", diff8, 8'h01);

    // Reset together with start from IDLE
    @(negedge clk);
    reset = 1'b1; start8 = 1'b1; a8 = 8'h09; b8 = 8'h01;
    @(posedge clk); #1 reset = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy8, 0);

    // Exhaustive WIDTH=2
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          op2(2'(ia), 2'(ib), 1'(ic), lat);
          ed = 2'(ia - ib - ic);
          eb = (ia < ib + ic);
          check("w2_lat", lat, 3);
          check("w2_diff", diff2, ed);
          check("w2_bout", bout2, eb);
        end
    @(negedge clk);
    check("w2_dones", dones2, 32);

`ifdef SUB_OVERFLOW_EN
    op8(8'h80, 8'h01, 1'b0, lat, busyc, dchg);
    check("ovf_diff1", diff8, 8'h7F);
    check("ovf_flag1", ovf8, 1);
    op8(8'h05, 8'h03, 1'b0, lat, busyc, dchg);
    check("ovf_diff2", diff8, 8'h02);
    check("ovf_flag2", ovf8, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Sequential LSB-first subtractor: computes diff = a - b - b_in over WIDTH clocks.
- Uses one full-subtractor cell (the borrow dual of the 1-bit full adder cell) and a registered borrow.
- Sits beside the gate-level full-adder blocks as the area-minimal arithmetic counterpart for multi-bit operands.
- Start/done handshake; result held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- b_in  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff and b_out are valid.
- diff  output  WIDTH  result; held from done until the next accepted start completes.
- b_out  output  1  final borrow-out; held like diff.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-high, on port reset.
  - Reset values: busy=0, done=0, diff=0, b_out=0. State goes to IDLE; shift registers, borrow flop and counter are cleared.
- State machine:
  - States: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> capture a, b, b_in into a_sh, b_sh, br; cnt=0; go to SHIFT.
  - SHIFT: busy=1. Each clock:
    - d = a_sh[0] ^ b_sh[0] ^ br
    - br <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
    - d shifts into diff MSB while diff shifts right; a_sh and b_sh shift right; cnt increments.
    - When cnt == WIDTH-1, that clock processes the last bit: b_out <= borrow result, go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle.
    - start=1 in DONE is accepted (back-to-back), same as IDLE -> SHIFT.
    - Otherwise go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. That is WIDTH SHIFT cycles plus the DONE cycle, i.e. done is visible WIDTH+1 cycles after the start edge. Throughput is one op per WIDTH+1 cycles.
- Arithmetic: diff = (a - b - b_in) mod 2^WIDTH. b_out=1 iff a < b + b_in as unsigned values.
- Boundary conditions:
  - start while busy is ignored. No queuing, no effect on the in-flight operation.
  - a, b, b_in changing after capture do not affect the result.
  - diff and b_out must not show intermediate shift values during SHIFT. Use an internal shift register, then update the visible diff and b_out on the SHIFT->DONE transition only.
  - reset asserted mid-SHIFT aborts the operation. Next cycle: all outputs at reset values, state IDLE. A start in the same cycle as reset is ignored.
  - cnt is sized to $clog2(WIDTH) bits and never wraps inside an operation.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow flag.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - Updated together with diff on SHIFT->DONE and held alongside diff; reset value 0.
  - b_in does not enter the overflow term beyond its effect on diff.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic subtract: WIDTH=8; a=0x5A, b=0x23, b_in=0, start pulse -> done exactly 9 cycles after the start edge; diff=0x37, b_out=0; busy high for 8 cycles.
- Borrow out: a=0x00, b=0x01, b_in=0 -> diff=0xFF, b_out=1. Then a=0x10, b=0x0F, b_in=1 issued back-to-back during the DONE cycle -> diff=0x00, b_out=0, with no idle cycle in between.
- Start while busy: start a=0xF0, b=0x0F; assert start again at cycle 3 with a=0x00, b=0xFF -> second request ignored; diff=0xE1, b_out=0; only one done pulse.
- Reset mid-operation: assert reset at SHIFT cycle 4 -> next cycle busy=0, done=0, diff=0x00, b_out=0. A fresh start a=0x02, b=0x01 then gives diff=0x01.
- Exhaustive: WIDTH=2, all 32 combinations of a, b, b_in -> diff and b_out match the (a - b - b_in) reference model; done count = 32.
- With SUB_OVERFLOW_EN, WIDTH=8:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x05, b=0x03 -> diff=0x02, ovf=0.
